cpu_mem_unit: RTL and testbench

//  Byte-serial memory access sequencer for the x86 core family. It turns one segment:offset

---
 rtl/cpu_mem_unit.sv | 133 +++++++++++++
 tb/tb_cpu_mem_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_unit.sv
// Byte-serial segment:offset memory access sequencer driving an 8-bit RAM bus.
// Optional wait-state support via CPU_MEMU_WAIT_EN (adds the mem_ready input).
module cpu_mem_unit #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned SEG_SHIFT = 4,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned LEN_W     = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     wr,
  input  logic [15:0]              seg,
  input  logic [15:0]              off,
  input  logic [LEN_W-1:0]         len,
  input  logic [8*MAX_BYTES-1:0]   wdata,
  output logic                     ready,
  output logic                     done,
  output logic [8*MAX_BYTES-1:0]   rdata,
  output logic [ADDR_W-1:0]        address,
  input  logic [7:0]               i_data,
`ifdef CPU_MEMU_WAIT_EN
  input  logic                     mem_ready,
`endif
  output logic [7:0]               o_data,
  output logic                     we
);

  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam int unsigned SUM_W  = ADDR_W + SEG_SHIFT + 17;

  typedef enum logic {IDLE, XFER} state_t;

  state_t              r_state, w_state_next;
  logic [15:0]         r_seg, r_off, w_off_next;
  logic [LEN_W-1:0]    r_cnt, r_len, w_cnt_next;
  logic                r_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          w_next_byte;
  logic                w_accept, w_step, w_last, w_mem_ready;

`ifdef CPU_MEMU_WAIT_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  // Physical address: the 16-bit offset never carries into the segment; only the
  // final sum wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] phys(input logic [15:0] s, input logic [15:0] o);
    logic [SUM_W-1:0] w_sum;
    w_sum = (SUM_W'(s) << SEG_SHIFT) + SUM_W'(o);
    return w_sum[ADDR_W-1:0];
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = (r_cnt == r_len);
    w_cnt_next   = r_cnt + LEN_W'(1);
    w_off_next   = r_off + 16'd1;
    w_next_byte  = '0;
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      if (w_cnt_next == LEN_W'(b)) w_next_byte = r_wdata[8*b +: 8];
    end
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept     = 1'b1;
          w_state_next = XFER;
        end
      end
      XFER: begin
        if (w_mem_ready) begin
          w_step = 1'b1;
          if (w_last) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign ready = (r_state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_seg   <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      done    <= 1'b0;
      rdata   <= '0;
      address <= '0;
      o_data  <= '0;
      we      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      done    <= 1'b0;
      if (w_accept) begin
        r_seg   <= seg;
        r_off   <= off;
        r_cnt   <= '0;
        r_len   <= len;
        r_wr    <= wr;
        r_wdata <= wdata;
        rdata   <= '0;
        address <= phys(seg, off);
        o_data  <= wdata[7:0];
        we      <= wr;
      end else if (w_step) begin
        if (!r_wr) begin
          for (int unsigned b = 0; b < MAX_BYTES; b++) begin
            if (r_cnt == LEN_W'(b)) rdata[8*b +: 8] <= i_data;
          end
        end
        if (w_last) begin
          we   <= 1'b0;
          done <= 1'b1;
        end else begin
          r_cnt   <= w_cnt_next;
          r_off   <= w_off_next;
          address <= phys(r_seg, w_off_next);
          o_data  <= w_next_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_unit.sv
// Self-checking bench for cpu_mem_unit: directed scenarios plus randomized transfers
// against a byte-level reference memory and address model.
module tb_cpu_mem_unit;

  localparam int unsigned AW = 20;

  logic        clock = 1'b0;
  logic        reset, req, wr;
  logic [15:0] seg, off;
  logic [1:0]  len;
  logic [31:0] wdata;
  logic        ready, done, we;
  logic [31:0] rdata;
  logic [AW-1:0] address;
  logic [7:0]  i_data, o_data;
`ifdef CPU_MEMU_WAIT_EN
  logic        mem_ready = 1'b1;
`endif

  cpu_mem_unit #(.ADDR_W(20), .SEG_SHIFT(4), .MAX_BYTES(4), .LEN_W(2)) dut (
    .clock(clock), .reset(reset), .req(req), .wr(wr), .seg(seg), .off(off),
    .len(len), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .address(address), .i_data(i_data),
`ifdef CPU_MEMU_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .o_data(o_data), .we(we)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [0:(1<<AW)-1];
  assign i_data = ram[address];
  always @(posedge clock) if (we) ram[address] <= o_data;

  logic [7:0] ref_mem [int unsigned];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int unsigned exp_addr(int unsigned s, int unsigned o, int unsigned k);
    return ((s * 16) + ((o + k) % 65536)) % (1 << AW);
  endfunction

  task automatic preload(input int unsigned a, input logic [7:0] v);
    ram[a] <= v;
    ref_mem[a] = v;
  endtask

  task automatic run_xfer(input logic [15:0] s, input logic [15:0] o, input logic [1:0] l,
                          input logic w, input logic [31:0] wd);
    int unsigned n;
    int unsigned a [4];
    logic [31:0] exp_rd;
    n = int'(l) + 1;
    exp_rd = '0;
    for (int unsigned k = 0; k < n; k++) begin
      a[k] = exp_addr(s, o, k);
      if (!w) exp_rd |= 32'(ref_mem[a[k]]) << (8 * k);
    end
    @(negedge clock);
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL xfer_ready_idle: got %b want 1", ready); end
    req = 1'b1; wr = w; seg = s; off = o; len = l; wdata = wd;
    @(posedge clock); #1;
    req = 1'b0; wr = 1'($urandom); seg = 16'($urandom); off = 16'($urandom);
    len = 2'($urandom); wdata = $urandom;
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clock);
      n_checks++;
      if (32'(address) !== a[k]) begin
        n_fail++; $display("FAIL xfer_addr[%0d]: got %h want %h", k, address, a[k]);
      end
      n_checks++;
      if (we !== w) begin n_fail++; $display("FAIL xfer_we[%0d]: got %b want %b", k, we, w); end
      if (w) begin
        n_checks++;
        if (o_data !== wd[8*k +: 8]) begin
          n_fail++; $display("FAIL xfer_odata[%0d]: got %h want %h", k, o_data, wd[8*k +: 8]);
        end
      end
      n_checks++;
      if ({ready, done} !== 2'b00) begin
        n_fail++; $display("FAIL xfer_busy[%0d]: ready/done got %b want 00", k, {ready, done});
      end
    end
    @(negedge clock);
    n_checks++;
    if ({done, ready, we} !== 3'b110) begin
      n_fail++; $display("FAIL xfer_done: done/ready/we got %b want 110", {done, ready, we});
    end
    n_checks++;
    if (rdata !== exp_rd) begin n_fail++; $display("FAIL xfer_rdata: got %h want %h", rdata, exp_rd); end
    if (w) begin
      for (int unsigned k = 0; k < n; k++) begin
        ref_mem[a[k]] = wd[8*k +: 8];
        n_checks++;
        if (ram[a[k]] !== ref_mem[a[k]]) begin
          n_fail++; $display("FAIL xfer_ram[%h]: got %h want %h", a[k], ram[a[k]], ref_mem[a[k]]);
        end
      end
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || rdata !== exp_rd) begin
      n_fail++; $display("FAIL xfer_hold: done %b rdata %h want 0 %h", done, rdata, exp_rd);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b1; wr = 1'b1; seg = 16'h1234; off = 16'h5678; len = 2'd3;
    wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({ready, done, we} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctrl: ready/done/we got %b want 100", {ready, done, we});
    end
    n_checks++;
    if (address !== '0 || o_data !== '0 || rdata !== '0) begin
      n_fail++; $display("FAIL reset_data: addr %h odata %h rdata %h want 0", address, o_data, rdata);
    end
    reset = 1'b0; req = 1'b0; wr = 1'b0;
    @(negedge clock);
    n_checks++;
    if (ready !== 1'b1 || we !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready %b we %b want 1 0", ready, we);
    end
  endtask

  task automatic test_read;
    preload(32'h12350, 8'h34);
    preload(32'h12351, 8'h12);
    run_xfer(16'h1234, 16'h0010, 2'd1, 1'b0, 32'h0);
  endtask

  task automatic test_write;
    run_xfer(16'h0000, 16'h0100, 2'd3, 1'b1, 32'hDEADBEEF);
  endtask

  task automatic test_offset_wrap;
    preload(32'h2FFFF, 8'hA5);
    preload(32'h20000, 8'h5A);
    preload(32'h30000, 8'hEE);
    run_xfer(16'h2000, 16'hFFFF, 2'd1, 1'b0, 32'h0);
  endtask

  task automatic test_phys_wrap;
    preload(32'h00000, 8'h77);
    run_xfer(16'hFFFF, 16'h0010, 2'd0, 1'b0, 32'h0);
  endtask

  task automatic test_random;
    logic [15:0] s, o;
    logic [1:0]  l;
    logic        w;
    for (int unsigned t = 0; t < 24; t++) begin
      s = 16'($urandom);
      o = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
      l = 2'($urandom);
      w = 1'($urandom);
      if (!w) begin
        for (int unsigned k = 0; k <= int'(l); k++) preload(exp_addr(s, o, k), 8'($urandom));
      end
      run_xfer(s, o, l, w, $urandom);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned a0, a1, b0;
    a0 = exp_addr(16'h0400, 16'h0020, 0);
    a1 = exp_addr(16'h0400, 16'h0020, 1);
    b0 = exp_addr(16'h0400, 16'h0080, 0);
    preload(a0, 8'h3C);
    preload(a1, 8'hC3);
    @(negedge clock);
    req = 1'b1; wr = 1'b0; seg = 16'h0400; off = 16'h0020; len = 2'd1; wdata = '0;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++;
    if (32'(address) !== a0) begin n_fail++; $display("FAIL b2b_addr0: got %h want %h", address, a0); end
    @(negedge clock);
    n_checks++;
    if (32'(address) !== a1) begin n_fail++; $display("FAIL b2b_addr1: got %h want %h", address, a1); end
    wr = 1'b1; off = 16'h0080; len = 2'd0; wdata = 32'h0000_005A;
    @(negedge clock);
    n_checks++;
    if ({done, ready} !== 2'b11 || rdata !== 32'h0000_C33C) begin
      n_fail++; $display("FAIL b2b_first_done: done/ready %b rdata %h want 11 0000c33c", {done, ready}, rdata);
    end
    @(posedge clock); #1;
    req = 1'b0;
    @(negedge clock);
    n_checks++;
    if (32'(address) !== b0 || we !== 1'b1 || o_data !== 8'h5A || ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_accept: addr %h we %b odata %h ready %b want %h 1 5a 0",
                         address, we, o_data, ready, b0);
    end
    @(negedge clock);
    n_checks++;
    if ({done, we} !== 2'b10 || ram[b0] !== 8'h5A) begin
      n_fail++; $display("FAIL b2b_second_done: done/we %b ram %h want 10 5a", {done, we}, ram[b0]);
    end
    ref_mem[b0] = 8'h5A;
  endtask

  task automatic test_ignore_busy;
    int unsigned a [4];
    logic [31:0] exp_rd;
    int bad;
    exp_rd = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      a[k] = exp_addr(16'h0300, 16'h0040, k);
      preload(a[k], 8'($urandom));
    end
    @(negedge clock);
    for (int unsigned k = 0; k < 4; k++) exp_rd |= 32'(ref_mem[a[k]]) << (8 * k);
    req = 1'b1; wr = 1'b0; seg = 16'h0300; off = 16'h0040; len = 2'd3; wdata = '0;
    @(posedge clock); #1;
    req = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 1) begin req = 1'b1; wr = 1'b1; off = 16'h0900; wdata = 32'h1111_1111; end
      else req = 1'b0;
      n_checks++;
      if (32'(address) !== a[k]) begin
        n_fail++; $display("FAIL busy_addr[%0d]: got %h want %h", k, address, a[k]);
      end
    end
    req = 1'b0;
    @(negedge clock);
    n_checks++;
    if (done !== 1'b1 || rdata !== exp_rd) begin
      n_fail++; $display("FAIL busy_done: done %b rdata %h want 1 %h", done, rdata, exp_rd);
    end
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if ({done, ready, we} !== 3'b010) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL busy_no_extra: %0d bad idle cycles, want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int unsigned a [4];
    int bad;
    for (int unsigned k = 0; k < 4; k++) begin
      a[k] = exp_addr(16'h0010, 16'h0500, k);
      preload(a[k], 8'h80 + 8'(k));
    end
    @(negedge clock);
    req = 1'b1; wr = 1'b1; seg = 16'h0010; off = 16'h0500; len = 2'd3; wdata = 32'hA1B2C3D4;
    @(posedge clock); #1;
    req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (32'(address) !== a[1] || we !== 1'b1) begin
      n_fail++; $display("FAIL rmid_byte1: addr %h we %b want %h 1", address, we, a[1]);
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({we, ready, done} !== 3'b010) begin
      n_fail++; $display("FAIL rmid_after_reset: we/ready/done got %b want 010", {we, ready, done});
    end
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (done !== 1'b0 || we !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rmid_no_done: %0d cycles with done/we, want 0", bad); end
    ref_mem[a[0]] = 8'hD4;
    ref_mem[a[1]] = 8'hC3;
    for (int unsigned k = 0; k < 4; k++) begin
      n_checks++;
      if (ram[a[k]] !== ref_mem[a[k]]) begin
        n_fail++; $display("FAIL rmid_ram[%0d]: got %h want %h", k, ram[a[k]], ref_mem[a[k]]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; seg = '0; off = '0; len = '0; wdata = '0;
    test_reset();
    test_read();
    test_write();
    test_offset_wrap();
    test_phys_wrap();
    test_back_to_back();
    test_ignore_busy();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
